// File: rtl/gol_pkg.sv
// Shared definitions for the 8x8 toroidal Game of Life array
// and its display path.
package gol_pkg;

  localparam int unsigned GRID_SIZE = 8;
  localparam int unsigned CELLS     = GRID_SIZE * GRID_SIZE;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Flat bit position of cell (x,y): x is column, y is row.
  function automatic int unsigned cell_idx(
    input int unsigned x,
    input int unsigned y
  );
    return x + GRID_SIZE * y;
  endfunction

endpackage

// File: rtl/gol_row_popcount.sv
// Live-cell count of one display row.
// Purely combinational; feeds the frame population accumulator.
module gol_row_popcount (
  input  logic [7:0] i_bits,
  output logic [3:0] o_count
);

  // Sum the eight cell bits.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < 8; i++) begin
      o_count = o_count + {3'b000, i_bits[i]};
    end
  end

endmodule

// File: rtl/gol_matrix_scan.sv
// Row-multiplexed LED matrix driver for the GoL array.
// Double-buffers generations so a frame never tears.
module gol_matrix_scan
  import gol_pkg::*;
#(
  parameter int ROW_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [63:0] i_vals,
  input  logic        i_gen_valid,
  output logic [7:0]  o_row,
  output logic [7:0]  o_col,
  output logic        o_frame_done,
  output logic [6:0]  o_pop
);

  localparam int MAX_CYC =
    (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CW =
    (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [7:0]    INV        = {8{ACTIVE_LOW}};

  scan_state_t   state_q;
  scan_state_t   state_d;
  logic [2:0]    row_q;
  logic [2:0]    row_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          boundary;

  logic [63:0]   pend_buf;
  logic          pend_flag;
  logic [63:0]   disp_buf;

  logic [7:0]    row_bits [GRID_SIZE];
  logic [3:0]    row_pc;
  logic          first_show;
  logic [6:0]    pop_acc;
  logic [6:0]    pop_sum;
  logic [7:0]    row_drv;
  logic [7:0]    col_drv;

  for (genvar g = 0; g < GRID_SIZE; g++) begin : g_rows
    assign row_bits[g] = disp_buf[cell_idx(0, g) +: 8];
  end

  gol_row_popcount u_pc (
    .i_bits  (row_bits[row_q]),
    .o_count (row_pc)
  );

  assign first_show = (state_q == SHOW) && (cnt_q == '0);
  assign pop_sum    = pop_acc
                    + (first_show ? {3'b000, row_pc} : 7'd0);

  // Scan sequencing: dwell counting, row advance, frame edge.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == ROW_LAST) begin
          state_d  = BLANK;
          cnt_d    = '0;
          row_d    = row_q + 3'd1;
          boundary = (row_q == 3'd7);
        end
      end
    endcase
  end

  // Pin values for the upcoming cycle, so outputs are registered.
  always_comb begin
    row_drv = '0;
    col_drv = '0;
    if (state_d == SHOW) begin
      row_drv = 8'd1 << row_d;
      col_drv = row_bits[row_d];
    end
  end

  // Scan state and counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= BLANK;
      row_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending capture and commit at the frame edge only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_buf  <= '0;
      pend_flag <= 1'b0;
      disp_buf  <= '0;
    end else begin
      if (i_gen_valid) begin
        pend_buf  <= i_vals;
        pend_flag <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end
      if (boundary && pend_flag) begin
        disp_buf <= pend_buf;
      end
    end
  end

  // Population accumulation and per-frame report.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pop_acc <= '0;
      o_pop   <= '0;
    end else if (boundary) begin
      o_pop   <= pop_sum;
      pop_acc <= '0;
    end else if (first_show) begin
      pop_acc <= pop_sum;
    end
  end

  // Registered pins, polarity applied here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_row        <= INV;
      o_col        <= INV;
      o_frame_done <= 1'b0;
    end else begin
      o_row        <= row_drv ^ INV;
      o_col        <= col_drv ^ INV;
      o_frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_gol_matrix_scan.sv
// Directed bench for gol_matrix_scan (row 4, blank 2 cycles).
// Active-high and active-low copies run side by side.
module tb_gol_matrix_scan;
  import gol_pkg::*;

  localparam int RC   = 4;
  localparam int BC   = 2;
  localparam int NCYC = 372;
  localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;

  logic        clk = 1'b0;
  logic        rst;
  logic        gv;
  logic [63:0] vals;
  logic [7:0]  row_h;
  logic [7:0]  col_h;
  logic [7:0]  row_l;
  logic [7:0]  col_l;
  logic        fd_h;
  logic        fd_l;
  logic [6:0]  pop_h;
  logic [6:0]  pop_l;

  always #5 clk = ~clk;

  gol_matrix_scan #(
    .ROW_CYCLES   (RC),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1'b0)
  ) u_hi (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_vals       (vals),
    .i_gen_valid  (gv),
    .o_row        (row_h),
    .o_col        (col_h),
    .o_frame_done (fd_h),
    .o_pop        (pop_h)
  );

  gol_matrix_scan #(
    .ROW_CYCLES   (RC),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1'b1)
  ) u_lo (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_vals       (vals),
    .i_gen_valid  (gv),
    .o_row        (row_l),
    .o_col        (col_l),
    .o_frame_done (fd_l),
    .o_pop        (pop_l)
  );

  typedef struct {
    bit          chk;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        fd;
    logic [6:0]  pop;
    bit          gv;
    bit          setv;
    logic [63:0] vals;
    bit          rst;
  } vec_t;

  vec_t tbl [NCYC];
  int   total = 0;
  int   bad   = 0;

  // Expected outputs for one 48-cycle frame showing disp.
  task automatic add_frame(
    input int          base,
    input logic [63:0] disp,
    input logic        fd,
    input logic [6:0]  pop
  );
    for (int k = 0; k < 8 * (RC + BC); k++) begin
      int c;
      int r;
      int ph;
      c  = base + k;
      r  = k / (RC + BC);
      ph = k % (RC + BC);
      if (c < NCYC) begin
        tbl[c].chk = 1'b1;
        tbl[c].fd  = (k == 0) ? fd : 1'b0;
        tbl[c].pop = pop;
        if (ph < BC) begin
          tbl[c].row = 8'h00;
          tbl[c].col = 8'h00;
        end else begin
          tbl[c].row = 8'(1 << r);
          tbl[c].col = disp[cell_idx(0, r) +: 8];
        end
      end
    end
  endtask

  task automatic chk(
    input string      nm,
    input int         c,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, c, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      tbl[i].chk  = 1'b0;
      tbl[i].row  = '0;
      tbl[i].col  = '0;
      tbl[i].fd   = 1'b0;
      tbl[i].pop  = '0;
      tbl[i].gv   = 1'b0;
      tbl[i].setv = 1'b0;
      tbl[i].vals = '0;
      tbl[i].rst  = 1'b0;
    end

    add_frame(0,   64'h0,  1'b0, 7'd0);
    add_frame(48,  GLIDER, 1'b1, 7'd0);
    add_frame(96,  64'h1,  1'b1, 7'd5);
    add_frame(144, GLIDER, 1'b1, 7'd1);
    add_frame(192, 64'hFF, 1'b1, 7'd5);
    add_frame(240, 64'hFF, 1'b1, 7'd8);
    add_frame(274, 64'h0,  1'b0, 7'd0);
    add_frame(322, 64'h0,  1'b1, 7'd0);
    add_frame(370, 64'h0,  1'b1, 7'd0);

    tbl[10]  = '{chk: tbl[10].chk, row: tbl[10].row,
                 col: tbl[10].col, fd: tbl[10].fd,
                 pop: tbl[10].pop, gv: 1'b1, setv: 1'b1,
                 vals: GLIDER, rst: 1'b0};
    tbl[60].setv  = 1'b1;
    tbl[60].vals  = '1;
    tbl[70].gv    = 1'b1;
    tbl[70].setv  = 1'b1;
    tbl[70].vals  = GLIDER;
    tbl[80].gv    = 1'b1;
    tbl[80].setv  = 1'b1;
    tbl[80].vals  = 64'h1;
    tbl[110].gv   = 1'b1;
    tbl[110].setv = 1'b1;
    tbl[110].vals = GLIDER;
    tbl[143].gv   = 1'b1;
    tbl[143].setv = 1'b1;
    tbl[143].vals = 64'hFF;
    tbl[250].gv   = 1'b1;
    tbl[250].setv = 1'b1;
    tbl[250].vals = GLIDER;
    tbl[273].rst  = 1'b1;

    rst  = 1'b1;
    gv   = 1'b0;
    vals = '0;
    repeat (2) @(negedge clk);

    for (int c = 0; c < NCYC; c++) begin
      if (c > 0) @(negedge clk);
      if (tbl[c].chk) begin
        chk("row", c, row_h, tbl[c].row);
        chk("col", c, col_h, tbl[c].col);
        chk("frame_done", c, {7'd0, fd_h}, {7'd0, tbl[c].fd});
        chk("pop", c, {1'b0, pop_h}, {1'b0, tbl[c].pop});
      end
      chk("row_inv", c, row_l, ~row_h);
      chk("col_inv", c, col_l, ~col_h);
      chk("fd_lo", c, {7'd0, fd_l}, {7'd0, tbl[c].fd});
      chk("pop_lo", c, {1'b0, pop_l}, {1'b0, tbl[c].pop});
      gv  = tbl[c].gv;
      rst = tbl[c].rst;
      if (tbl[c].setv) vals = tbl[c].vals;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
